arbitro_display: RTL and testbench
==================================

// Module: arbitro_display
// PURPOSE
//   Shares the 4-digit 7-segment display between two requesters (A, B) with a
//   req/grant handshake. Round-robin on contention, minimum dwell time per owner,
//   blanking gap between owners. Outputs feed the four digit inputs of the display
//   controller; o_Blank gates its anodes off during idle/gap.
// PARAMETERS
//   DWELL_TICKS  50_000_000  min cycles an owner keeps the display when the other requests
//   GAP_TICKS    5_000_000   blank cycles between owners (0 = no gap)
//   CNT_W        26          timer width; must hold max(DWELL_TICKS, GAP_TICKS)
// PORTS
//   i_Clk      in   1   system clock, all logic on rising edge
//   i_Rst      in   1   reset, synchronous, active-high
//   i_Req_A    in   1   requester A wants the display (level, held while needed)
//   i_Datos_A  in   16  A digits: [3:0] digit1 .. [15:12] digit4
//   i_Req_B    in   1   requester B wants the display
//   i_Datos_B  in   16  B digits, same packing
//   o_Gnt_A    out  1   A owns the display
//   o_Gnt_B    out  1   B owns the display
//   o_Datos1   out  4   digit 1 to display controller (owner bits [3:0])
//   o_Datos2   out  4   digit 2 (owner bits [7:4])
//   o_Datos3   out  4   digit 3 (owner bits [11:8])
//   o_Datos4   out  4   digit 4 (owner bits [15:12])
//   o_Blank    out  1   1 = no owner, display must be dark
// BEHAVIOUR
//   - Reset (sync, i_Rst=1): state IDLE, timer 0, last-served ptr = B (A wins first tie);
//     o_Gnt_A=o_Gnt_B=0, o_Blank=1, o_Datos1..4=0. Holds while i_Rst=1.
//   - States: IDLE, SERV_A, SERV_B, GAP. Grants/blank decoded from state register.
//   - IDLE: one req -> SERV_<req>; both -> the one not last served. Grant visible 1
//     cycle after req sampled. No req -> stay.
//   - SERV_X: o_Gnt_X=1, o_Blank=0, o_Datos = live i_Datos_X (comb. mux on state reg,
//     so data and grant coincide). Timer clears on entry, counts up, saturates at
//     DWELL_TICKS-1 (expired). Exit to GAP when i_Req_X=0 (any time, dwell ignored)
//     or (expired and other req=1). Expired with no other req: stay, no rearbitration.
//     Ptr <= X on exit.
//   - GAP: grants 0, o_Blank=1, o_Datos=0 for GAP_TICKS cycles, then arbitrate as in
//     IDLE (both -> not-last-served; none -> IDLE). GAP_TICKS=0: skip GAP, arbitrate in
//     the exit cycle's next state directly. Req changes inside GAP only matter at end.
//   - Grants are one-hot or zero; never both high.
//   - Reset mid-operation: next cycle all outputs at reset values, ptr reset.
//   - DWELL_TICKS >= 1. Timer compares at full CNT_W width; no wrap.
// STRUCTURE
//   - Package arbitro_display_pkg: state localparams (ST_IDLE=2'd0, ST_SERV_A=2'd1,
//     ST_SERV_B=2'd2, ST_GAP=2'd3), digit width 4, bus width 16.
//   - Sub-module contador_tiempo: sync clear, enable, programmable terminal value,
//     saturating, o_Fin flag; one instance shared by dwell and gap (exclusive states).
//   - Top: FSM + ptr register + output mux.
// TESTING  (DWELL_TICKS=8, GAP_TICKS=2)
//   1. i_Rst=1 for 3 cycles, reqs high -> Gnt_A=Gnt_B=0, o_Blank=1, o_Datos1..4=0.
//   2. Req_A=1, Datos_A=16'h1234 at c0 -> c1: Gnt_A=1, Datos4..1=1,2,3,4, Blank=0;
//      held 20 cycles, no switch; Datos_A->16'hABCD at c10 -> outputs follow c10.
//   3. A owns from c1, Req_B=1 at c3 -> Gnt_A through c8, c9-c10 Blank=1 gnts 0,
//      c11 Gnt_B=1 with B data.
//   4. After reset Req_A=Req_B=1 same cycle -> A first; A drops, next tie -> B.
//   5. Req_A drops at c4 of dwell, no B -> 2 gap cycles blank, then IDLE, Blank=1.
//   6. i_Rst=1 during SERV_B -> next cycle gnts 0, Blank=1; then tie -> A wins.

Source files
------------

// File: rtl/arbitro_display_pkg.sv
// Shared types and constants for the two-requester display arbiter.
// The state encoding is fixed because the states are exposed to other logic.
package arbitro_display_pkg;

  localparam int DIG_W = 4;
  localparam int BUS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERV_A = 2'd1,
    ST_SERV_B = 2'd2,
    ST_GAP    = 2'd3
  } estado_t;

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_t;

  // Round-robin choice: on a tie the requester not served last wins.
  function automatic estado_t arbitrar(input logic req_a, input logic req_b,
                                       input ptr_t ultimo);
    estado_t res;
    res = ST_IDLE;
    if (req_a && req_b) res = (ultimo == PTR_A) ? ST_SERV_B : ST_SERV_A;
    else if (req_a)     res = ST_SERV_A;
    else if (req_b)     res = ST_SERV_B;
    return res;
  endfunction

endpackage

// File: rtl/arbitro_display_contador_tiempo.sv
// Saturating up-counter with synchronous clear; o_Fin flags the terminal value.
// One instance serves both the dwell and the gap timing.
module contador_tiempo #(
  parameter int CNT_W = 26
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Clr,
  input  logic             i_En,
  input  logic [CNT_W-1:0] i_Fin_Val,
  output logic             o_Fin
);

  logic [CNT_W-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (i_Clr)                           cuenta_d = '0;
    else if (i_En && cuenta_q < i_Fin_Val) cuenta_d = cuenta_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) cuenta_q <= '0;
    else       cuenta_q <= cuenta_d;
  end

  assign o_Fin = (cuenta_q >= i_Fin_Val);

endmodule

// File: rtl/arbitro_display.sv
// Shares one 4-digit 7-segment display between requesters A and B with
// round-robin, minimum dwell per owner and a blank gap between owners.
module arbitro_display
  import arbitro_display_pkg::*;
#(
  parameter int DWELL_TICKS = 50_000_000,
  parameter int GAP_TICKS   = 5_000_000,
  parameter int CNT_W       = 26
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Req_A,
  input  logic [BUS_W-1:0] i_Datos_A,
  input  logic             i_Req_B,
  input  logic [BUS_W-1:0] i_Datos_B,
  output logic             o_Gnt_A,
  output logic             o_Gnt_B,
  output logic [DIG_W-1:0] o_Datos1,
  output logic [DIG_W-1:0] o_Datos2,
  output logic [DIG_W-1:0] o_Datos3,
  output logic [DIG_W-1:0] o_Datos4,
  output logic             o_Blank
);

  localparam logic [CNT_W-1:0] DWELL_FIN = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_FIN   = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  estado_t          estado_q, estado_d;
  ptr_t             ptr_q, ptr_d;
  logic             fin;
  logic             tmr_clr, tmr_en;
  logic [CNT_W-1:0] tmr_fin_val;
  logic [BUS_W-1:0] datos;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    estado_d = estado_q;
    ptr_d    = ptr_q;
    unique case (estado_q)
      ST_IDLE: estado_d = arbitrar(i_Req_A, i_Req_B, ptr_q);
      ST_SERV_A: begin
        if (!i_Req_A || (fin && i_Req_B)) begin
          ptr_d    = PTR_A;
          estado_d = (GAP_TICKS == 0) ? arbitrar(i_Req_A, i_Req_B, PTR_A) : ST_GAP;
        end
      end
      ST_SERV_B: begin
        if (!i_Req_B || (fin && i_Req_A)) begin
          ptr_d    = PTR_B;
          estado_d = (GAP_TICKS == 0) ? arbitrar(i_Req_A, i_Req_B, PTR_B) : ST_GAP;
        end
      end
      ST_GAP: if (fin) estado_d = arbitrar(i_Req_A, i_Req_B, ptr_q);
      default: estado_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      estado_q <= ST_IDLE;
      ptr_q    <= PTR_B;
    end else begin
      estado_q <= estado_d;
      ptr_q    <= ptr_d;
    end
  end

  // Timer restarts on every state change, so each owner and each gap start at zero.
  assign tmr_clr     = (estado_d != estado_q) || (estado_q == ST_IDLE);
  assign tmr_en      = (estado_q != ST_IDLE);
  assign tmr_fin_val = (estado_q == ST_GAP) ? GAP_FIN : DWELL_FIN;

  contador_tiempo #(.CNT_W(CNT_W)) u_contador (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Clr    (tmr_clr),
    .i_En     (tmr_en),
    .i_Fin_Val(tmr_fin_val),
    .o_Fin    (fin)
  );

  always_comb begin
    datos = '0;
    unique case (estado_q)
      ST_SERV_A: datos = i_Datos_A;
      ST_SERV_B: datos = i_Datos_B;
      default:   datos = '0;
    endcase
  end

  assign o_Gnt_A  = (estado_q == ST_SERV_A);
  assign o_Gnt_B  = (estado_q == ST_SERV_B);
  assign o_Blank  = !(o_Gnt_A || o_Gnt_B);
  assign o_Datos1 = datos[3:0];
  assign o_Datos2 = datos[7:4];
  assign o_Datos3 = datos[11:8];
  assign o_Datos4 = datos[15:12];

endmodule

// File: tb/tb_arbitro_display.sv
// Self-checking bench for arbitro_display: reference model feeds a scoreboard
// of expected owners; directed scenarios add fixed-cycle timing checks.
module tb_arbitro_display;

  localparam int DWELL = 8;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        rst, ra, rb;
  logic [15:0] da, db;
  logic        gnt_a, gnt_b, blank;
  logic [3:0]  d1, d2, d3, d4;

  always #5 clk = ~clk;

  arbitro_display #(.DWELL_TICKS(DWELL), .GAP_TICKS(GAP), .CNT_W(26)) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Req_A  (ra),
    .i_Datos_A(da),
    .i_Req_B  (rb),
    .i_Datos_B(db),
    .o_Gnt_A  (gnt_a),
    .o_Gnt_B  (gnt_b),
    .o_Datos1 (d1),
    .o_Datos2 (d2),
    .o_Datos3 (d3),
    .o_Datos4 (d4),
    .o_Blank  (blank)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: owner plus cycles spent in the current service/gap.
  typedef enum int {M_IDLE, M_A, M_B, M_GAP} mown_t;
  mown_t m_own = M_IDLE;
  int    m_age = 0;
  int    m_gap = 0;
  bit    m_last_a = 1'b0;
  mown_t sb_q[$];

  int    cyc, first_a, first_b, last_a;
  logic  obs_gnt_a, obs_gnt_b, obs_blank;
  logic [15:0] obs_dat;

  function automatic mown_t pick(input bit a, input bit b, input bit last_a_v);
    if (a && b) return last_a_v ? M_B : M_A;
    if (a) return M_A;
    if (b) return M_B;
    return M_IDLE;
  endfunction

  task automatic enter(input mown_t nxt);
    m_own = nxt;
    m_age = 1;
  endtask

  task automatic serve(input bit own_req, input bit other_req, input bit is_a);
    if (!own_req || (m_age >= DWELL && other_req)) begin
      m_last_a = is_a;
      if (GAP > 0) begin
        m_own = M_GAP;
        m_gap = 1;
      end else enter(pick(ra, rb, m_last_a));
    end else m_age++;
  endtask

  task automatic model_step();
    if (rst) begin
      m_own = M_IDLE; m_last_a = 1'b0; m_age = 0; m_gap = 0;
    end else begin
      case (m_own)
        M_IDLE:  enter(pick(ra, rb, m_last_a));
        M_A:     serve(ra, rb, 1'b1);
        M_B:     serve(rb, ra, 1'b0);
        default: if (m_gap >= GAP) enter(pick(ra, rb, m_last_a)); else m_gap++;
      endcase
    end
  endtask

  // One clock cycle: drive inputs, compare against the owner queued at the
  // previous edge, then advance the model at the edge.
  task automatic cycle(input bit r, input bit a, input logic [15:0] dav,
                       input bit b, input logic [15:0] dbv);
    mown_t exp_own;
    logic [15:0] exp_dat;
    rst = r; ra = a; da = dav; rb = b; db = dbv;
    #1;
    obs_gnt_a = gnt_a; obs_gnt_b = gnt_b; obs_blank = blank;
    obs_dat   = {d4, d3, d2, d1};
    if (sb_q.size() > 0) begin
      exp_own = sb_q.pop_front();
      exp_dat = (exp_own == M_A) ? da : (exp_own == M_B) ? db : 16'h0;
      check("gnt_a", obs_gnt_a, exp_own == M_A);
      check("gnt_b", obs_gnt_b, exp_own == M_B);
      check("blank", obs_blank, (exp_own == M_IDLE) || (exp_own == M_GAP));
      check("datos", obs_dat, exp_dat);
    end
    if (obs_gnt_a) last_a = cyc;
    if (obs_gnt_a && first_a < 0) first_a = cyc;
    if (obs_gnt_b && first_b < 0) first_b = cyc;
    @(posedge clk);
    model_step();
    sb_q.push_back(m_own);
    @(negedge clk);
    cyc++;
  endtask

  task automatic scen_reset();
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    cyc = 0; first_a = -1; first_b = -1; last_a = -1;
  endtask

  initial begin
    bit ra_r, rb_r, rs_r;
    logic [15:0] da_r, db_r;
    cyc = 0; first_a = -1; first_b = -1; last_a = -1;

    // 1: reset held with both requests high
    for (int c = 0; c < 3; c++) cycle(1'b1, 1'b1, 16'hFFFF, 1'b1, 16'hEEEE);
    check("s1_gnt_a", obs_gnt_a, 1'b0);
    check("s1_gnt_b", obs_gnt_b, 1'b0);
    check("s1_blank", obs_blank, 1'b1);
    check("s1_datos", obs_dat, 16'h0);

    // 2: lone requester keeps the display, data follows live input
    scen_reset();
    for (int c = 0; c < 21; c++) begin
      cycle(1'b0, 1'b1, (c >= 10) ? 16'hABCD : 16'h1234, 1'b0, 16'h5555);
      if (c == 1)  check("s2_c1_datos", obs_dat, 16'h1234);
      if (c == 10) check("s2_c10_datos", obs_dat, 16'hABCD);
      if (c == 20) check("s2_hold_gnt", obs_gnt_a, 1'b1);
    end

    // 3: contention after minimum dwell, then gap, then B
    scen_reset();
    for (int c = 0; c < 15; c++) cycle(1'b0, 1'b1, 16'h1111, c >= 3, 16'h2222);
    check("s3_last_gnt_a", last_a, 8);
    check("s3_first_gnt_b", first_b, 11);

    // 4: tie after reset goes to A, next tie goes to B
    scen_reset();
    for (int c = 0; c < 9; c++) cycle(1'b0, (c < 3) || (c >= 5), 16'h0A0A, 1'b1, 16'h0B0B);
    check("s4_first_gnt_a", first_a, 1);
    check("s4_first_gnt_b", first_b, 6);

    // 5: owner drops early with no contender -> gap then idle
    scen_reset();
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, c < 4, 16'h4321, 1'b0, 16'h0);
      if (c == 7) check("s5_idle_blank", obs_blank, 1'b1);
    end
    check("s5_last_gnt_a", last_a, 4);

    // 6: reset while B is served, then tie -> A
    scen_reset();
    for (int c = 0; c < 8; c++) begin
      cycle(c == 3, c >= 3, 16'h7777, 1'b1, 16'h8888);
      if (c == 2) check("s6_gnt_b", obs_gnt_b, 1'b1);
      if (c == 4) check("s6_rst_gnt_b", obs_gnt_b, 1'b0);
    end
    check("s6_first_gnt_a", first_a, 5);

    // Random traffic against the model
    ra_r = 0; rb_r = 0; da_r = 16'h0; db_r = 16'h0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 9) == 0) ra_r = ~ra_r;
      if ($urandom_range(0, 9) == 0) rb_r = ~rb_r;
      if ($urandom_range(0, 3) == 0) da_r = 16'($urandom);
      if ($urandom_range(0, 3) == 0) db_r = 16'($urandom);
      rs_r = ($urandom_range(0, 249) == 0);
      cycle(rs_r, ra_r, da_r, rb_r, db_r);
      check("onehot", {31'b0, obs_gnt_a & obs_gnt_b}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
